// File: rtl/code_seq_pkg.sv
// ---------------------------------------------------------------------------
// code_seq_pkg
// Shared types and constants for the code sequencer:
//   seq_state_t - sequencer FSM states
//   CODE_W/CODE_MAX - width and top value of the 3-bit code
//   TICK_W - auto-step prescaler width
// Helper functions give the modulo-8 advance and the wrap condition.
// ---------------------------------------------------------------------------
package code_seq_pkg;

    localparam int              CODE_W   = 3;
    localparam logic [CODE_W-1:0] CODE_MAX = 3'd7;
    localparam int              TICK_W   = 26;

    typedef enum logic [1:0] {
        S_MANUAL = 2'd0,
        S_AUTO   = 2'd1,
        S_PAUSE  = 2'd2
    } seq_state_t;

    // Modulo-8 step; natural 3-bit overflow gives 7->0 and 0->7.
    function automatic logic [CODE_W-1:0] next_code(input logic [CODE_W-1:0] code,
                                                     input logic              down);
        return down ? code - 3'd1 : code + 3'd1;
    endfunction

    // True when the advance about to happen crosses the wrap boundary.
    function automatic logic is_wrap(input logic [CODE_W-1:0] code, input logic down);
        return down ? (code == '0) : (code == CODE_MAX);
    endfunction

endpackage

// File: rtl/code_sequencer_if.sv
// ---------------------------------------------------------------------------
// code_sequencer_if
// Board-side signal bundle of the code sequencer.
//   KEY_STEP  - push button, active-low, asynchronous
//   SW_MODE   - 0 manual, 1 auto, asynchronous
//   SW_DIR    - 0 up, 1 down, asynchronous
//   C         - 3-bit code to the seven-segment decoder
//   LEDR_RUN  - high while auto-stepping
//   WRAP      - one-cycle wrap pulse (only with CODE_SEQ_WRAP_PULSE_EN)
// Modports: master drives the board inputs, slave is the sequencer.
// ---------------------------------------------------------------------------
interface code_sequencer_if;
    import code_seq_pkg::*;

    logic              KEY_STEP;
    logic              SW_MODE;
    logic              SW_DIR;
    logic [CODE_W-1:0] C;
    logic              LEDR_RUN;

`ifdef CODE_SEQ_WRAP_PULSE_EN
    logic              WRAP;

    modport master (output KEY_STEP, SW_MODE, SW_DIR, input  C, LEDR_RUN, WRAP);
    modport slave  (input  KEY_STEP, SW_MODE, SW_DIR, output C, LEDR_RUN, WRAP);
`else
    modport master (output KEY_STEP, SW_MODE, SW_DIR, input  C, LEDR_RUN);
    modport slave  (input  KEY_STEP, SW_MODE, SW_DIR, output C, LEDR_RUN);
`endif

endinterface

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Synchronizes an asynchronous active-low push button, debounces it and
// emits a one-cycle pulse on each accepted press (1->0 of the debounced level).
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   key_n_async  - raw button level
//   key_db       - debounced level (reset 1 = released)
//   step_p       - registered one-cycle press pulse
// Parameter DEB_CYCLES (>= 2): consecutive differing samples needed to accept
// a level change.
// ---------------------------------------------------------------------------
module key_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_async,
    output logic key_db,
    output logic step_p
);

    localparam int CNT_W = $clog2(DEB_CYCLES);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_db_q, key_db_d;
    logic             key_db_dly_q, key_db_dly_d;
    logic             step_p_q, step_p_d;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        sync1_d      = key_n_async;
        sync2_d      = sync1_q;
        cnt_d        = '0;
        key_db_d     = key_db_q;
        key_db_dly_d = key_db_q;

        if (sync2_q != key_db_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                key_db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Press is the fall of the debounced level; release gives nothing.
        step_p_d = key_db_dly_q & ~key_db_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            cnt_q        <= '0;
            key_db_q     <= 1'b1;
            key_db_dly_q <= 1'b1;
            step_p_q     <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            cnt_q        <= cnt_d;
            key_db_q     <= key_db_d;
            key_db_dly_q <= key_db_dly_d;
            step_p_q     <= step_p_d;
        end
    end

    assign key_db = key_db_q;
    assign step_p = step_p_q;

endmodule

// File: rtl/code_sequencer.sv
// ---------------------------------------------------------------------------
// code_sequencer
// Generates the 3-bit code for the seven-segment decoder. The code steps on a
// debounced button press (manual) or on a prescaled tick (auto), up or down
// modulo 8. A press in auto toggles pause; the mode switch always wins.
// Ports:
//   CLOCK_50 - clock
//   RESET_N  - asynchronous active-low reset
//   bus      - code_sequencer_if.slave (KEY_STEP, SW_MODE, SW_DIR in;
//              C, LEDR_RUN [, WRAP] out, all outputs registered)
// Parameters: TICK_DIV (>= 2) clocks per auto step, DEB_CYCLES (>= 2).
// Optional: define CODE_SEQ_WRAP_PULSE_EN to drive bus.WRAP, a one-cycle
// pulse coincident with C showing a wrapped value (7->0 up, 0->7 down).
// ---------------------------------------------------------------------------
module code_sequencer
    import code_seq_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    code_sequencer_if.slave  bus
);

    logic              mode_s1_q, mode_s1_d, mode_s2_q, mode_s2_d;
    logic              dir_s1_q,  dir_s1_d,  dir_s2_q,  dir_s2_d;
    seq_state_t        state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              ledr_run_q, ledr_run_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;
    logic              advance;
    logic              step_p;
    logic              key_db_unused; // the press pulse carries all we need

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_key_debounce (
        .clk         (CLOCK_50),
        .rst_n       (RESET_N),
        .key_n_async (bus.KEY_STEP),
        .key_db      (key_db_unused),
        .step_p      (step_p)
    );

    always_comb begin
        mode_s1_d  = bus.SW_MODE;
        mode_s2_d  = mode_s1_q;
        dir_s1_d   = bus.SW_DIR;
        dir_s2_d   = dir_s1_q;
        state_d    = state_q;
        code_d     = code_q;
        advance    = 1'b0;
        tick_cnt_d = '0;
        tick       = (state_q == S_AUTO) && (tick_cnt_q == TICK_W'(TICK_DIV - 1));

        // A mode change pre-empts everything else in the same cycle.
        unique case (state_q)
            S_MANUAL: begin
                if (mode_s2_q)   state_d = S_AUTO;
                else if (step_p) advance = 1'b1;
            end
            S_AUTO: begin
                if (!mode_s2_q) begin
                    state_d = S_MANUAL;
                end else begin
                    advance = tick;
                    if (step_p) state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (!mode_s2_q)  state_d = S_MANUAL;
                else if (step_p) state_d = S_AUTO;
            end
            default: state_d = S_MANUAL;
        endcase

        if (advance) code_d = next_code(code_q, dir_s2_q);

        // Count only while staying in auto, so every entry restarts a full interval.
        if (state_q == S_AUTO && state_d == S_AUTO)
            tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

        ledr_run_d = (state_d == S_AUTO);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            mode_s1_q  <= 1'b0;
            mode_s2_q  <= 1'b0;
            dir_s1_q   <= 1'b0;
            dir_s2_q   <= 1'b0;
            state_q    <= S_MANUAL;
            code_q     <= '0;
            ledr_run_q <= 1'b0;
            tick_cnt_q <= '0;
        end else begin
            mode_s1_q  <= mode_s1_d;
            mode_s2_q  <= mode_s2_d;
            dir_s1_q   <= dir_s1_d;
            dir_s2_q   <= dir_s2_d;
            state_q    <= state_d;
            code_q     <= code_d;
            ledr_run_q <= ledr_run_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign bus.C        = code_q;
    assign bus.LEDR_RUN = ledr_run_q;

`ifdef CODE_SEQ_WRAP_PULSE_EN
    logic wrap_q, wrap_d;

    always_comb begin
        wrap_d = advance && is_wrap(code_q, dir_s2_q);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) wrap_q <= 1'b0;
        else          wrap_q <= wrap_d;
    end

    assign bus.WRAP = wrap_q;
`endif

endmodule

// File: tb/tb_code_sequencer.sv
// ---------------------------------------------------------------------------
// tb_code_sequencer
// Directed scenarios plus a randomized stretch, compared every cycle against a
// behavioural model built from the block's rules: inputs are seen two edges
// late, a level is accepted after three consecutive differing samples, the
// auto step fires every TICK_DIV edges spent in auto.
// ---------------------------------------------------------------------------
module tb_code_sequencer;

    localparam int TICK_DIV   = 4;
    localparam int DEB_CYCLES = 3;
    localparam int MAN = 0, AUTO = 1, PAUSE = 2;

    logic CLOCK_50 = 1'b0;
    logic RESET_N  = 1'b0;

    code_sequencer_if bus ();

    code_sequencer #(
        .TICK_DIV   (TICK_DIV),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int errors = 0;
    int checks = 0;
    int wrap_seen = 0;

    // Model: raw input samples, index i = taken i edges ago.
    logic kh [1:4];
    logic mh [1:2];
    logic dh [1:2];
    logic m_db, m_fell, m_step, m_wrap;
    int   m_mode, m_age, m_code;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 1; i <= 4; i++) kh[i] = 1'b1;
        for (int i = 1; i <= 2; i++) begin mh[i] = 1'b0; dh[i] = 1'b0; end
        m_db = 1'b1; m_fell = 1'b0; m_step = 1'b0; m_wrap = 1'b0;
        m_mode = MAN; m_age = 0; m_code = 0;
    endtask

    task automatic model_edge();
        logic step_used, mode_used, dir_used;
        int   nxt;
        bit   adv;
        step_used = m_step;
        mode_used = mh[2];
        dir_used  = dh[2];
        adv = 1'b0;
        nxt = m_mode;
        case (m_mode)
            MAN:  if (mode_used) nxt = AUTO; else if (step_used) adv = 1'b1;
            AUTO: if (!mode_used) nxt = MAN;
                  else begin
                      if ((m_age + 1) % TICK_DIV == 0) adv = 1'b1;
                      if (step_used) nxt = PAUSE;
                  end
            default: if (!mode_used) nxt = MAN; else if (step_used) nxt = AUTO;
        endcase
        m_wrap = adv && (dir_used ? (m_code == 0) : (m_code == 7));
        if (adv) m_code = dir_used ? (m_code + 7) % 8 : (m_code + 1) % 8;
        m_age  = (nxt == AUTO && m_mode == AUTO) ? m_age + 1 : 0;
        m_mode = nxt;
        // Press pulse follows the debounced fall by one edge.
        m_step = m_fell;
        m_fell = 1'b0;
        if (kh[2] !== m_db && kh[3] !== m_db && kh[4] !== m_db) begin
            m_db   = kh[2];
            m_fell = (kh[2] == 1'b0);
        end
        kh[4] = kh[3]; kh[3] = kh[2]; kh[2] = kh[1]; kh[1] = bus.KEY_STEP;
        mh[2] = mh[1]; mh[1] = bus.SW_MODE;
        dh[2] = dh[1]; dh[1] = bus.SW_DIR;
    endtask

    task automatic check_outputs();
        check("C", bus.C, m_code);
        check("LEDR_RUN", bus.LEDR_RUN, m_mode == AUTO);
`ifdef CODE_SEQ_WRAP_PULSE_EN
        check("WRAP", bus.WRAP, m_wrap);
`endif
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic cyc();
        @(posedge CLOCK_50);
        if (!RESET_N) model_reset();
        else          model_edge();
        @(negedge CLOCK_50);
`ifdef CODE_SEQ_WRAP_PULSE_EN
        if (bus.WRAP === 1'b1) wrap_seen++;
`endif
        check_outputs();
    endtask

    task automatic press(input int low_cycles, input int high_cycles);
        bus.KEY_STEP = 1'b0;
        repeat (low_cycles) cyc();
        bus.KEY_STEP = 1'b1;
        repeat (high_cycles) cyc();
    endtask

    task automatic wait_run(input logic level, input string tag, output int n);
        n = 0;
        while (bus.LEDR_RUN !== level && n < 12) begin cyc(); n++; end
        check(tag, bus.LEDR_RUN, level);
    endtask

    initial begin
        int n;
        int c_ref;
        int key_run;

        bus.KEY_STEP = 1'b1;
        bus.SW_MODE  = 1'b0;
        bus.SW_DIR   = 1'b0;
        model_reset();
        #1;
        check("reset_C", bus.C, 0);
        check("reset_LEDR", bus.LEDR_RUN, 0);
        repeat (2) cyc();
        RESET_N = 1'b1;
        repeat (4) cyc();

        // Manual up, nine presses, exact 6-edge latency, wrap 7->0.
        wrap_seen = 0;
        for (int i = 0; i < 9; i++) begin
            bus.KEY_STEP = 1'b0;
            repeat (5) cyc();
            bus.KEY_STEP = 1'b1;
            cyc();
            check("press_hold", bus.C, i % 8);
            cyc();
            check("press_step", bus.C, (i + 1) % 8);
            repeat (5) cyc();
        end
`ifdef CODE_SEQ_WRAP_PULSE_EN
        check("wrap_once", wrap_seen, 1);
`endif

        // Bounce rejection: no three consecutive low samples, then a clean press.
        press(1, 1); press(2, 1); press(1, 2); press(2, 2);
        check("bounce_none", bus.C, 1);
        press(5, 8);
        check("bounce_one", bus.C, 2);

        // Reset mid-count from C=5 with a press in progress.
        press(5, 8); press(5, 8); press(5, 8);
        check("pre_reset", bus.C, 5);
        bus.KEY_STEP = 1'b0;
        repeat (4) cyc();
        #2 RESET_N = 1'b0;
        #1;
        model_reset();
        check("async_rst_C", bus.C, 0);
        check("async_rst_LEDR", bus.LEDR_RUN, 0);
        @(negedge CLOCK_50);
        bus.KEY_STEP = 1'b1;
        repeat (2) cyc();
        RESET_N = 1'b1;
        repeat (10) cyc();
        check("after_rst_C", bus.C, 0);

        // Auto down from C=1: 1 -> 0 -> 7, four edges apart.
        press(5, 8);
        check("auto_start", bus.C, 1);
        bus.SW_DIR  = 1'b1;
        bus.SW_MODE = 1'b1;
        wait_run(1'b1, "auto_enter", n);
        check("mode_latency", n, 3);
        repeat (3) cyc();
        check("auto_hold", bus.C, 1);
        cyc();
        check("auto_first", bus.C, 0);
        repeat (3) cyc();
        check("auto_hold2", bus.C, 0);
        cyc();
        check("auto_second", bus.C, 7);

        // Pause and resume.
        bus.KEY_STEP = 1'b0;
        repeat (5) cyc();
        bus.KEY_STEP = 1'b1;
        wait_run(1'b0, "pause_enter", n);
        c_ref = m_code;
        for (int i = 0; i < 20; i++) begin
            cyc();
            check("pause_frozen", bus.C, c_ref);
            check("pause_led", bus.LEDR_RUN, 0);
        end
        bus.KEY_STEP = 1'b0;
        repeat (5) cyc();
        bus.KEY_STEP = 1'b1;
        wait_run(1'b1, "resume", n);
        c_ref = m_code;
        repeat (3) cyc();
        check("resume_hold", bus.C, c_ref);
        cyc();
        check("resume_step", bus.C, (c_ref + 7) % 8);
        repeat (6) cyc();

        // Synchronized mode fall and press pulse act on the same edge.
        bus.KEY_STEP = 1'b0;
        repeat (4) cyc();
        bus.SW_MODE = 1'b0;
        cyc();
        bus.KEY_STEP = 1'b1;
        cyc();
        c_ref = m_code;
        check("simul_pre_led", bus.LEDR_RUN, 1);
        cyc();
        check("simul_led", bus.LEDR_RUN, 0);
        check("simul_C", bus.C, c_ref);
        repeat (10) cyc();
        check("simul_after_C", bus.C, c_ref);

        // Randomized stretch with one asynchronous reset in the middle.
        key_run = 0;
        for (int i = 0; i < 800; i++) begin
            if (key_run == 0) begin
                bus.KEY_STEP = ~bus.KEY_STEP;
                key_run = $urandom_range(1, 7);
            end
            key_run--;
            if ($urandom_range(0, 39) == 0) bus.SW_MODE = ~bus.SW_MODE;
            if ($urandom_range(0, 24) == 0) bus.SW_DIR  = ~bus.SW_DIR;
            if (i == 400) begin
                #2 RESET_N = 1'b0;
                #1;
                model_reset();
                check("rand_rst_C", bus.C, 0);
                @(negedge CLOCK_50);
                cyc();
                RESET_N = 1'b1;
            end
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/code_sequencer.md
# code_sequencer

Upstream stage of the 3-bit-code-to-seven-segment decoder: generates the 3-bit code `C[2:0]` that the decoder turns into `HEX0`. The code is stepped either manually by a debounced push button or automatically by a prescaled tick, counting up or down with wrap-around. All board inputs are asynchronous and are synchronized inside the block. `C` is fully registered and glitch-free.

## Interface

Parameters:
- `TICK_DIV`, default 50_000_000: `CLOCK_50` cycles per auto-step (1 Hz). Must be ≥ 2.
- `DEB_CYCLES`, default 1_000_000: consecutive stable synchronized cycles needed to accept a button level change (20 ms). Must be ≥ 2.

Ports:
- `CLOCK_50`: input, 1 bit. Single clock for the block.
- `RESET_N`: input, 1 bit. Asynchronous, active-low reset.
- `KEY_STEP`: input, 1 bit. Push button, active-low, asynchronous, bouncy.
- `SW_MODE`: input, 1 bit. 0 = manual, 1 = auto. Asynchronous.
- `SW_DIR`: input, 1 bit. 0 = count up, 1 = count down. Asynchronous.
- `C`: output, 3 bits. Code to the decoder. Registered.
- `LEDR_RUN`: output, 1 bit. High while in `S_AUTO`. Registered.

## Operation

- **Synchronizers.** Each of `KEY_STEP`, `SW_MODE` and `SW_DIR` passes through a 2-flop synchronizer.
  - Reset values: `KEY_STEP` path 1, switch paths 0.
  - Switches are not debounced.
- **Debouncer.**
  - Holds a debounced level `key_db` (reset 1) and a stable counter (reset 0).
  - When the synchronized key differs from `key_db`, the counter increments each cycle. When it reaches `DEB_CYCLES-1` while still differing, `key_db` takes the new level and the counter clears.
  - Any cycle where the synchronized key equals `key_db` clears the counter.
- **Edge detect.** A 1→0 transition of `key_db` produces a registered one-cycle `step_p` pulse. Release produces nothing.
- **FSM.** Encoding in the package; reset state is `S_MANUAL`.
  - `S_MANUAL`: `step_p` advances `C`. If synchronized `SW_MODE`=1, go to `S_AUTO`.
  - `S_AUTO`: the prescaler runs and each tick advances `C`.
    - `step_p`: go to `S_PAUSE`.
    - `SW_MODE`=0: go to `S_MANUAL`.
  - `S_PAUSE`: `C` is frozen.
    - `step_p`: go to `S_AUTO`.
    - `SW_MODE`=0: go to `S_MANUAL`.
- **Prescaler.**
  - The 26-bit counter runs only in `S_AUTO` and is held at 0 in the other states.
  - A tick occurs when the count equals `TICK_DIV-1`; the count then wraps to 0.
- **Advance rule.**
  - Up: `C+1`, with 7→0.
  - Down: `C-1`, with 0→7.
  - Arithmetic is modulo 8. The direction is sampled on the advance edge.
- **Priority.** When a synchronized `SW_MODE` change and `step_p` land in the same cycle, the mode change wins and `step_p` is discarded (no advance, no pause toggle).
- **Reset mid-operation.** An asynchronous reset immediately returns `C` to 0, the state to `S_MANUAL`, and clears all counters. A press in progress is lost.

## Timing

- Reset values: `C`=3'b000, `LEDR_RUN`=0.
- Press latency: if `KEY_STEP` is held low from sampling edge k onward, `step_p` is high in the cycle after edge k+2+`DEB_CYCLES`. `C` updates on the next edge.
- Bounces shorter than `DEB_CYCLES` cycles produce no pulse.
- Auto rate: the first advance occurs `TICK_DIV` edges after entering `S_AUTO`, then every `TICK_DIV` edges. Resuming from `S_PAUSE` restarts the full interval.
- `LEDR_RUN` changes on the same edge as the state register.
- Mode-switch latency is 2 edges (synchronizer) plus 1 edge (state).

## Configuration

- `CODE_SEQ_WRAP_PULSE_EN`
  - Defined: adds output port `WRAP` (1 bit, registered, reset 0). `WRAP` is high for exactly one cycle, coincident with the first cycle in which `C` shows a wrapped value: 7→0 when counting up, 0→7 when counting down. Manual and auto advances both count.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure

- Package `code_seq_pkg` holds:
  - the state enum `seq_state_t` (`S_MANUAL`, `S_AUTO`, `S_PAUSE`);
  - the constants `CODE_W`=3 and `CODE_MAX`=3'd7;
  - the prescaler width `TICK_W`=26.
- Sub-module `key_debounce`: 2-flop synchronizer, stable counter, and falling-edge pulse. Parameter `DEB_CYCLES`; outputs `key_db` and `step_p`.

## Test plan

All scenarios use `TICK_DIV`=4 and `DEB_CYCLES`=3.

1. **Reset.** Assert `RESET_N`=0 mid-count with `C`=5 → `C`=0 and `LEDR_RUN`=0 immediately. After release with `SW_MODE`=0, `C` stays 0.
2. **Manual up with wrap.** Manual mode, `SW_DIR`=0, 9 clean presses → `C` sequence 1…7,0,1. `C` updates exactly 2+3+1 edges after each press starts. With the macro defined, `WRAP` pulses once, at 7→0.
3. **Bounce rejection.** `KEY_STEP` toggles low/high with low pulses of 1–2 cycles, then held low for 5 cycles → exactly one advance.
4. **Auto down.** `SW_MODE`=1, `SW_DIR`=1, starting from `C`=1 → `C`=0 and then `C`=7, 4 edges apart. The first change is 4 edges after `LEDR_RUN` rises.
5. **Pause/resume.** In auto, a press → `S_PAUSE`: `C` is frozen for 20 cycles and `LEDR_RUN`=0. A second press → `S_AUTO`, and the next advance comes 4 edges later.
6. **Simultaneous events.** The synchronized `SW_MODE` fall and `step_p` coincide in `S_AUTO` → state `S_MANUAL`, `C` unchanged.
